// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse SerDes link: frame-decoder states and
// lane-word/field-width helpers used by both the serializer and the deserializer.
package sparse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    IDX,
    VAL,
    DONE
  } rx_state_e;

  // Width of the lane-word count inputs; supports fields up to 15 lane words.
  localparam int K_W = 4;

  function automatic int lane_words(input int width, input int lane_w);
    return (width + lane_w - 1) / lane_w;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sparse_field_collector.sv
// Shift-assembles one multi-word field from lane words, LSB word first.
// done and field are combinational with the final accepted word.
module sparse_field_collector
  import sparse_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int MAX_W  = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  input  logic                                          start,
  input  logic [LANE_W-1:0]                             data,
  input  logic [K_W-1:0]                                k,
  output logic                                          done,
  output logic [lane_words(MAX_W, LANE_W)*LANE_W-1:0]   field
);

  localparam int KMAX    = lane_words(MAX_W, LANE_W);
  localparam int FIELD_W = KMAX * LANE_W;

  logic [K_W-1:0]     wcnt;
  logic [K_W-1:0]     pos;
  logic [FIELD_W-1:0] acc;

  // NOTE: every always_comb output gets a value before any branch so no latch is inferred.
  always_comb begin
    pos   = start ? '0 : wcnt;
    field = start ? '0 : acc;
    for (int i = 0; i < KMAX; i++) begin
      if (pos == K_W'(i)) field[i*LANE_W +: LANE_W] = data;
    end
    done = in_valid && (pos + K_W'(1) == k);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      acc  <= '0;
    end else if (in_valid) begin
      if (done) begin
        wcnt <= '0;
        acc  <= '0;
      end else begin
        wcnt <= pos + K_W'(1);
        acc  <= field;
      end
    end
  end

endmodule

// File: rtl/sparse_deser_rx.sv
// Sparse-link receive deframer: decodes (count, {index, value}*) frames from
// the lane stream into a dense vector offered on a valid/ready port.
module sparse_deser_rx
  import sparse_pkg::*;
#(
  parameter int N      = 16,
  parameter int VAL_W  = 8,
  parameter int LANE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [LANE_W-1:0]    s_data,
  input  logic                 s_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*VAL_W-1:0]   out_vec,
  output logic                 out_bad,
  output logic                 err,
  output logic [7:0]           err_cnt
);

  localparam int IDX_W   = idx_width(N);
  localparam int CNT_W   = cnt_width(N);
  localparam int K_CNT   = lane_words(CNT_W, LANE_W);
  localparam int K_IDX   = lane_words(IDX_W, LANE_W);
  localparam int K_VAL   = lane_words(VAL_W, LANE_W);
  localparam int MAX_CI  = (CNT_W > IDX_W) ? CNT_W : IDX_W;
  localparam int MAX_W   = (VAL_W > MAX_CI) ? VAL_W : MAX_CI;
  localparam int FIELD_W = lane_words(MAX_W, LANE_W) * LANE_W;

  rx_state_e          state, next_state;
  logic               accept, cnt_phase;
  logic               col_in, col_start, col_done;
  logic [K_W-1:0]     col_k;
  logic [FIELD_W-1:0] field;
  logic [FIELD_W-1:0] idx_q;
  logic [CNT_W-1:0]   rem;
  logic               err_set, bad_set, load_rem, dec_rem, latch_idx, write_en;

  sparse_field_collector #(
    .LANE_W (LANE_W),
    .MAX_W  (MAX_W)
  ) u_collector (
    .clk      (clk),
    .rst      (rst),
    .in_valid (col_in),
    .start    (col_start),
    .data     (s_data),
    .k        (col_k),
    .done     (col_done),
    .field    (field)
  );

  assign accept    = s_valid & s_ready;
  assign col_in    = accept && (state != IDLE || s_sof);
  assign col_start = accept && s_sof;
  // A sof word always begins a count field, whatever state it arrives in.
  assign cnt_phase = s_sof || state == IDLE || state == HDR;
  assign col_k     = cnt_phase ? K_W'(K_CNT) : (state == IDX) ? K_W'(K_IDX) : K_W'(K_VAL);
  assign out_valid = (state == DONE);

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    bad_set    = 1'b0;
    load_rem   = 1'b0;
    dec_rem    = 1'b0;
    latch_idx  = 1'b0;
    write_en   = 1'b0;
    if (col_start) begin
      next_state = HDR;
      if (state != IDLE) err_set = 1'b1;
    end
    if (col_done) begin
      if (cnt_phase) begin
        if (field == '0) begin
          next_state = DONE;
        end else if (field > FIELD_W'(N)) begin
          next_state = IDLE;
          err_set    = 1'b1;
          bad_set    = 1'b1;
        end else begin
          next_state = IDX;
          load_rem   = 1'b1;
        end
      end else if (state == IDX) begin
        next_state = VAL;
        latch_idx  = 1'b1;
      end else if (state == VAL) begin
        dec_rem = 1'b1;
        if (idx_q < FIELD_W'(N)) begin
          write_en = 1'b1;
        end else begin
          err_set = 1'b1;
          bad_set = 1'b1;
        end
        next_state = (rem == CNT_W'(1)) ? DONE : IDX;
      end
    end
    if (state == DONE && out_ready) next_state = IDLE;
  end

  // NOTE: the dense vector is a plain register, not a RAM, so it is reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s_ready <= 1'b1;
      out_vec <= '0;
      out_bad <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      idx_q   <= '0;
      rem     <= '0;
    end else begin
      state   <= next_state;
      s_ready <= (next_state != DONE);
      err     <= err_set;
      if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (latch_idx) idx_q <= field;
      if (load_rem) rem <= field[CNT_W-1:0];
      else if (dec_rem) rem <= rem - CNT_W'(1);
      if (col_start) begin
        out_vec <= '0;
        out_bad <= 1'b0;
      end
      if (write_en) out_vec[idx_q[IDX_W-1:0]*VAL_W +: VAL_W] <= field[VAL_W-1:0];
      if (bad_set) out_bad <= 1'b1;
    end
  end

endmodule
